// File: rtl/dtack_pkg.sv
// rtl/dtack_pkg.sv - shared types and helpers for the DTACK/BERR generator
package dtack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    BERR,
    RECOVER
  } dtack_state_e;

  // Channel index meaning "no chip select"; truncated to the index width at use.
  localparam logic [3:0] NO_SEL = 4'hF;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dtack_prio_enc.sv
// rtl/dtack_prio_enc.sv - active-low chip-select priority encoder, bit 0 wins
module dtack_prio_enc
  import dtack_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req_n,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = IDX_W'(NO_SEL);
    valid = 1'b0;
    // Walk from the top so the lowest asserted index is the last one written.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (!req_n[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtack_gen.sv
// rtl/dtack_gen.sv - 68000 /DTACK and /BERR generator with per-channel wait states
module dtack_gen
  import dtack_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WS_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 as_n,
  input  logic [N_CH-1:0]      cs_n,
  input  logic [N_CH*WS_W-1:0] ws_cfg,
  input  logic [N_CH-1:0]      ext_en,
  input  logic [N_CH-1:0]      ext_dtack_n,
  output logic                 dtack_n,
  output logic                 berr_n,
  output logic                 busy
);

  localparam int IDX_W = clog2_min1(N_CH);
  localparam int TO_W  = clog2_min1(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_TERM = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WS_W-1:0] WS_MAX  = '1;

  dtack_state_e     state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic [WS_W-1:0]  ws_q, ws_d;
  logic             ext_q, ext_d;
  logic [WS_W-1:0]  wcnt_q, wcnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic             dtack_q, dtack_d;
  logic             berr_q, berr_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;
  logic [WS_W-1:0]  ws_new;
  logic             ext_en_new;
  logic             ext_sel_n;
  logic             ack;
  logic             to_hit;

  dtack_prio_enc #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req_n (cs_n),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Config for the channel being selected now, and the ack line of the latched one.
  always_comb begin
    ws_new     = '0;
    ext_en_new = 1'b0;
    ext_sel_n  = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (enc_idx == IDX_W'(i)) begin
        ws_new     = ws_cfg[i*WS_W +: WS_W];
        ext_en_new = ext_en[i];
      end
      if (sel_q == IDX_W'(i)) begin
        ext_sel_n = ext_dtack_n[i];
      end
    end
  end

  assign ack    = sel_valid_q && (ext_q ? !ext_sel_n : (wcnt_q == ws_q));
  assign to_hit = (TIMEOUT != 0) && (tcnt_q == TO_TERM);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    ws_d        = ws_q;
    ext_d       = ext_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    dtack_d     = dtack_q;
    berr_d      = berr_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (!as_n) begin
          state_d     = WAIT;
          sel_d       = enc_idx;
          sel_valid_d = enc_valid;
          ws_d        = enc_valid ? ws_new : '0;
          ext_d       = enc_valid && ext_en_new;
          wcnt_d      = '0;
          tcnt_d      = '0;
          busy_d      = 1'b1;
        end
      end
      WAIT: begin
        wcnt_d = (wcnt_q == WS_MAX) ? wcnt_q : wcnt_q + 1'b1;
        tcnt_d = (tcnt_q == TO_TERM) ? tcnt_q : tcnt_q + 1'b1;
        // Abort beats ack, ack beats timeout.
        if (as_n) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (ack) begin
          state_d = ACK;
          dtack_d = 1'b0;
        end else if (to_hit) begin
          state_d = BERR;
          berr_d  = 1'b0;
        end
      end
      ACK, BERR: begin
        if (as_n) begin
          state_d = RECOVER;
          dtack_d = 1'b1;
          berr_d  = 1'b1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= IDX_W'(NO_SEL);
      sel_valid_q <= 1'b0;
      ws_q        <= '0;
      ext_q       <= 1'b0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      dtack_q     <= 1'b1;
      berr_q      <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      ws_q        <= ws_d;
      ext_q       <= ext_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      dtack_q     <= dtack_d;
      berr_q      <= berr_d;
      busy_q      <= busy_d;
    end
  end

  assign dtack_n = dtack_q;
  assign berr_n  = berr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dtack_gen.sv
// tb/tb_dtack_gen.sv - directed self-checking bench for dtack_gen
module tb_dtack_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        as_n = 1'b1;
  logic [3:0]  cs_n = 4'hF;
  logic [15:0] ws_cfg = 16'h0000;
  logic [3:0]  ext_en = 4'h0;
  logic [3:0]  ext_dtack_n = 4'hF;
  logic        dtack_n, berr_n, busy;
  logic        nt_dtack_n, nt_berr_n, nt_busy;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dtack_gen #(.N_CH(4), .WS_W(4), .TIMEOUT(64)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .as_n        (as_n),
    .cs_n        (cs_n),
    .ws_cfg      (ws_cfg),
    .ext_en      (ext_en),
    .ext_dtack_n (ext_dtack_n),
    .dtack_n     (dtack_n),
    .berr_n      (berr_n),
    .busy        (busy)
  );

  dtack_gen #(.N_CH(4), .WS_W(4), .TIMEOUT(0)) u_dut_nt (
    .clk         (clk),
    .reset       (reset),
    .as_n        (as_n),
    .cs_n        (cs_n),
    .ws_cfg      (ws_cfg),
    .ext_en      (ext_en),
    .ext_dtack_n (ext_dtack_n),
    .dtack_n     (nt_dtack_n),
    .berr_n      (nt_berr_n),
    .busy        (nt_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic end_cycle();
    as_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    logic nt_hit;

    // Reset values
    step();
    check_eq("rst_dtack", dtack_n, 1);
    check_eq("rst_berr", berr_n, 1);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    step();

    // Internal channel 1, ws=3: dtack at edge 4; later cs/ws changes ignored
    ws_cfg = 16'h0030;
    cs_n   = 4'b1101;
    as_n   = 1'b0;
    step();
    check_eq("t1_busy_start", busy, 1);
    check_eq("t1_dtack_e0", dtack_n, 1);
    cs_n   = 4'b1110;
    ws_cfg = 16'h00F0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check_eq($sformatf("t1_dtack_e%0d", e), dtack_n, (e < 4) ? 1 : 0);
    end
    step();
    step();
    check_eq("t1_dtack_hold", dtack_n, 0);
    as_n = 1'b1;
    step();
    check_eq("t1_dtack_release", dtack_n, 1);
    check_eq("t1_busy_recover", busy, 1);
    step();
    check_eq("t1_busy_idle", busy, 0);

    // External channel 2; ext_dtack_n[0] toggles without effect
    cs_n        = 4'b1011;
    ext_en      = 4'b0100;
    ws_cfg      = 16'h0000;
    ext_dtack_n = 4'hF;
    as_n        = 1'b0;
    step();
    for (int e = 1; e <= 6; e++) begin
      ext_dtack_n[0] = ~ext_dtack_n[0];
      step();
      check_eq($sformatf("t2_dtack_e%0d", e), dtack_n, 1);
    end
    ext_dtack_n[2] = 1'b0;
    step();
    check_eq("t2_dtack_e7", dtack_n, 0);
    ext_dtack_n = 4'hF;
    end_cycle();
    check_eq("t2_busy_idle", busy, 0);
    ext_en = 4'h0;

    // No chip select: BERR at edge 64; the TIMEOUT=0 instance never errors
    cs_n   = 4'hF;
    as_n   = 1'b0;
    early  = 1'b0;
    nt_hit = 1'b0;
    step();
    for (int e = 1; e <= 999; e++) begin
      step();
      if (e < 64 && !berr_n) early = 1'b1;
      if (!nt_berr_n) nt_hit = 1'b1;
      if (e == 64) begin
        check_eq("t3_berr_e64", berr_n, 0);
        check_eq("t3_dtack_e64", dtack_n, 1);
      end
    end
    check_eq("t3_berr_early", early, 0);
    check_eq("t3_berr_hold", berr_n, 0);
    check_eq("t3_nt_berr", nt_hit, 0);
    check_eq("t3_nt_busy", nt_busy, 1);
    check_eq("t3_nt_dtack", nt_dtack_n, 1);
    as_n = 1'b1;
    step();
    check_eq("t3_berr_release", berr_n, 1);
    step();
    check_eq("t3_busy_idle", busy, 0);

    // Two selects, lowest wins (ch1 ws=0); as_n low during RECOVER not accepted
    cs_n   = 4'b1001;
    ws_cfg = 16'h0500;
    as_n   = 1'b0;
    step();
    step();
    check_eq("t4_dtack_e1", dtack_n, 0);
    as_n = 1'b1;
    step();
    check_eq("t4_dtack_release", dtack_n, 1);
    check_eq("t4_busy_recover", busy, 1);
    as_n = 1'b0;
    step();
    check_eq("t4_recover_no_accept", busy, 0);
    step();
    check_eq("t4_restart_busy", busy, 1);
    check_eq("t4_restart_dtack", dtack_n, 1);
    step();
    check_eq("t4_restart_ack", dtack_n, 0);
    end_cycle();

    // Abort of a ws=7 cycle on channel 3
    cs_n   = 4'b0111;
    ws_cfg = 16'h7000;
    as_n   = 1'b0;
    step();
    step();
    step();
    check_eq("t5_busy_e2", busy, 1);
    as_n = 1'b1;
    step();
    check_eq("t5_busy_e3", busy, 0);
    early = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (!dtack_n) early = 1'b1;
    end
    check_eq("t5_no_dtack", early, 0);

    // Asynchronous reset while in ACK
    cs_n   = 4'b1110;
    ws_cfg = 16'h0000;
    as_n   = 1'b0;
    step();
    step();
    check_eq("t6_dtack_ack", dtack_n, 0);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_dtack", dtack_n, 1);
    check_eq("t6_rst_berr", berr_n, 1);
    check_eq("t6_rst_busy", busy, 0);
    step();
    check_eq("t6_rst_hold_busy", busy, 0);
    reset = 1'b1;
    step();
    check_eq("t6_restart_busy", busy, 1);
    step();
    check_eq("t6_restart_ack", dtack_n, 0);
    end_cycle();
    check_eq("t6_busy_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
